// File: rtl/riscv_dmem_pkg.sv
// Shared types and helpers for the RISC-V data-memory access sequencer.
// The split feature itself is selected by RISCV_DMEM_SPLIT_MISALIGNED_EN in the users of this package.
package riscv_dmem_pkg;

    localparam int DMEM_WIDTH_NARROW = 32;
    localparam int DMEM_WIDTH_WIDE   = 64;

    typedef enum logic [1:0] {
        SIZE_BYTE   = 2'd0,
        SIZE_HALF   = 2'd1,
        SIZE_WORD   = 2'd2,
        SIZE_DOUBLE = 2'd3
    } dmem_size_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BEAT0 = 3'd1,
        ST_BEAT1 = 3'd2,
        ST_FAULT = 3'd3,
        ST_RESP  = 3'd4
    } dmem_state_e;

    function automatic bit dmem_width_ok(input int width);
        return (width == DMEM_WIDTH_NARROW) || (width == DMEM_WIDTH_WIDE);
    endfunction

    // Lane mask spanning two beats; callers keep the low 2*NB bits.
    function automatic logic [15:0] dmem_byte_mask(input logic [2:0] offset, input dmem_size_e size);
        logic [15:0] ones;
        ones = (16'h1 << (4'h1 << size)) - 16'h1;
        return ones << offset;
    endfunction

endpackage

// File: rtl/riscv_dmem_lane_align.sv
// Byte-lane steering: store-data rotation, load-data merge/rotate and sign/zero extension.
// With RISCV_DMEM_SPLIT_MISALIGNED_EN the read path merges two beats; otherwise it uses one.
module riscv_dmem_lane_align
    import riscv_dmem_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    localparam int NB         = DATA_WIDTH / 8,
    localparam int OB         = $clog2(NB)
) (
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [OB-1:0]         wr_offset,
    output logic [DATA_WIDTH-1:0] wdata_rot,
    input  logic [DATA_WIDTH-1:0] rdata_lo,
`ifdef RISCV_DMEM_SPLIT_MISALIGNED_EN
    input  logic [DATA_WIDTH-1:0] rdata_hi,
`endif
    input  logic [OB-1:0]         rd_offset,
    input  dmem_size_e            rd_size,
    input  logic                  rd_signed,
    output logic [DATA_WIDTH-1:0] rdata_out
);

    logic [DATA_WIDTH-1:0] shifted;
    logic                  sign_bit;
    int                    nbytes;

    // Rotate-left by whole bytes: upper half of the doubled word shifted left.
    assign wdata_rot = DATA_WIDTH'(({wdata, wdata} << {wr_offset, 3'b000}) >> DATA_WIDTH);

`ifdef RISCV_DMEM_SPLIT_MISALIGNED_EN
    assign shifted = DATA_WIDTH'({rdata_hi, rdata_lo} >> {rd_offset, 3'b000});
`else
    assign shifted = rdata_lo >> {rd_offset, 3'b000};
`endif

    always_comb begin
        nbytes    = 1 << rd_size;
        sign_bit  = 1'b0;
        rdata_out = '0;
        for (int i = 0; i < NB; i++) begin
            if (i == nbytes - 1) sign_bit = shifted[8*i+7];
        end
        for (int i = 0; i < NB; i++) begin
            rdata_out[8*i +: 8] = (i < nbytes) ? shifted[8*i +: 8] : {8{rd_signed & sign_bit}};
        end
    end

endmodule

// File: rtl/riscv_dmem_access_sequencer.sv
// Data-memory access engine: one request at a time, one or two bus beats, single-cycle response.
// Define RISCV_DMEM_SPLIT_MISALIGNED_EN to split misaligned accesses instead of faulting them.
module riscv_dmem_access_sequencer
    import riscv_dmem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [1:0]              req_size,
    input  logic                    req_signed,
    input  logic [ADDR_WIDTH-1:0]   req_address,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    bus_valid,
    output logic                    bus_write,
    output logic [ADDR_WIDTH-1:0]   bus_address,
    output logic [DATA_WIDTH/8-1:0] bus_byte_enable,
    output logic [DATA_WIDTH-1:0]   bus_wdata,
    input  logic                    bus_ack,
    input  logic [DATA_WIDTH-1:0]   bus_rdata,
    output logic                    resp_valid,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_fault
);
    // state    | meaning
    // ST_IDLE  | ready for a request
    // ST_BEAT0 | first (or only) bus beat outstanding
    // ST_BEAT1 | second beat of a word-crossing access
    // ST_FAULT | rejected request, no bus activity
    // ST_RESP  | one-cycle response pulse

    localparam int NB = DATA_WIDTH / 8;
    localparam int OB = $clog2(NB);

    generate
        if (!dmem_width_ok(DATA_WIDTH)) begin : g_bad_width
            $error("riscv_dmem_access_sequencer: DATA_WIDTH must be 32 or 64");
        end
    endgenerate

    dmem_state_e           state, state_next;
    dmem_size_e            req_size_e, size_q;
    logic [OB-1:0]         req_offset, offset_q;
    logic [2*NB-1:0]       req_mask;
    logic                  size_illegal, req_fault, accept;
    logic                  signed_q, fault_q;
    logic [DATA_WIDTH-1:0] wdata_rot, rdata_merged, rdata_lo;

    assign req_size_e   = dmem_size_e'(req_size);
    assign req_offset   = req_address[OB-1:0];
    assign req_mask     = (2*NB)'(dmem_byte_mask(3'(req_offset), req_size_e));
    assign size_illegal = req_size > 2'(OB);
    assign accept       = (state == ST_IDLE) && req_valid;

`ifdef RISCV_DMEM_SPLIT_MISALIGNED_EN
    logic [NB-1:0]         mask_hi_q;
    logic [DATA_WIDTH-1:0] rdata0_q;

    assign req_fault = size_illegal;
    assign rdata_lo  = (state == ST_BEAT1) ? rdata0_q : bus_rdata;
    assign bus_valid = (state == ST_BEAT0) || (state == ST_BEAT1);
`else
    logic [OB-1:0] align_bits;

    // Anything misaligned, or reaching into a second beat, is rejected.
    assign align_bits = OB'((4'h1 << req_size) - 4'h1);
    assign req_fault  = size_illegal || ((req_offset & align_bits) != '0) || (|req_mask[2*NB-1:NB]);
    assign rdata_lo   = bus_rdata;
    assign bus_valid  = (state == ST_BEAT0);
`endif

    assign req_ready  = (state == ST_IDLE);
    assign resp_valid = (state == ST_RESP);
    assign resp_fault = resp_valid && fault_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:  if (req_valid) state_next = req_fault ? ST_FAULT : ST_BEAT0;
            ST_FAULT: state_next = ST_RESP;
            ST_BEAT0: begin
                if (bus_ack) begin
`ifdef RISCV_DMEM_SPLIT_MISALIGNED_EN
                    state_next = (|mask_hi_q) ? ST_BEAT1 : ST_RESP;
`else
                    state_next = ST_RESP;
`endif
                end
            end
`ifdef RISCV_DMEM_SPLIT_MISALIGNED_EN
            ST_BEAT1: if (bus_ack) state_next = ST_RESP;
`endif
            ST_RESP:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus_write       <= 1'b0;
            bus_address     <= '0;
            bus_byte_enable <= '0;
            bus_wdata       <= '0;
            resp_rdata      <= '0;
            offset_q        <= '0;
            size_q          <= SIZE_BYTE;
            signed_q        <= 1'b0;
            fault_q         <= 1'b0;
`ifdef RISCV_DMEM_SPLIT_MISALIGNED_EN
            mask_hi_q       <= '0;
            rdata0_q        <= '0;
`endif
        end else begin
            if (accept) begin
                offset_q        <= req_offset;
                size_q          <= req_size_e;
                signed_q        <= req_signed;
                fault_q         <= req_fault;
                resp_rdata      <= '0;
                bus_write       <= req_write;
                bus_address     <= {req_address[ADDR_WIDTH-1:OB], {OB{1'b0}}};
                bus_byte_enable <= req_mask[NB-1:0];
                bus_wdata       <= wdata_rot;
`ifdef RISCV_DMEM_SPLIT_MISALIGNED_EN
                mask_hi_q       <= req_mask[2*NB-1:NB];
`endif
            end
`ifdef RISCV_DMEM_SPLIT_MISALIGNED_EN
            if ((state == ST_BEAT0) && bus_ack && (|mask_hi_q)) begin
                rdata0_q        <= bus_rdata;
                bus_address     <= bus_address + ADDR_WIDTH'(NB);
                bus_byte_enable <= mask_hi_q;
            end else if (bus_valid && bus_ack && !bus_write) begin
                resp_rdata <= rdata_merged;
            end
`else
            if (bus_valid && bus_ack && !bus_write) resp_rdata <= rdata_merged;
`endif
        end
    end

    riscv_dmem_lane_align #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_lane_align (
        .wdata     (req_wdata),
        .wr_offset (req_offset),
        .wdata_rot (wdata_rot),
        .rdata_lo  (rdata_lo),
`ifdef RISCV_DMEM_SPLIT_MISALIGNED_EN
        .rdata_hi  (bus_rdata),
`endif
        .rd_offset (offset_q),
        .rd_size   (size_q),
        .rd_signed (signed_q),
        .rdata_out (rdata_merged)
    );

endmodule
